mem_access_ctrl: RTL and testbench

Initiator-side controller for the single-port data Memory (Status 0 = read, 1 = write; word Address; write data I; read data Q).
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake.
- Performs sub-word extraction with sign or zero extension on loads.
- Performs read-modify-write for byte and half-word stores.
- Returns one response pulse per request.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller: access sizes, FSM states
// and the request legality check.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_e;

    // True for an illegal size or an address not aligned to the access size.
    function automatic logic access_error(input size_e size, input logic [1:0] lane);
        logic err;
        case (size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = lane[0];
            SIZE_W:  err = |lane;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends a load field from a memory
// word, and merges a right-aligned store field into an old word.
module mem_lane_align
    import mem_ctrl_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  size_e               size_i,
    input  logic [1:0]          lane_i,
    input  logic                unsigned_i,
    input  logic [WordSize-1:0] old_word_i,
    input  logic [WordSize-1:0] store_data_i,
    output logic [WordSize-1:0] load_data_o,
    output logic [WordSize-1:0] merged_word_o
);

    logic [4:0]          shamt;
    logic [WordSize-1:0] field_mask;
    logic [WordSize-1:0] shifted;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        shamt      = '0;
        field_mask = '1;
        case (size_i)
            SIZE_B: begin
                shamt      = {lane_i, 3'b000};
                field_mask = {{(WordSize-8){1'b0}}, 8'hFF};
            end
            SIZE_H: begin
                shamt      = {lane_i[1], 4'b0000};
                field_mask = {{(WordSize-16){1'b0}}, 16'hFFFF};
            end
            default: ;
        endcase
    end

    assign shifted = old_word_i >> shamt;

    always_comb begin
        load_data_o = shifted;
        case (size_i)
            SIZE_B: load_data_o = {{(WordSize-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
            SIZE_H: load_data_o = {{(WordSize-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign merged_word_o = (old_word_i & ~(field_mask << shamt))
                         | ((store_data_i & field_mask) << shamt);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a level-sensitive single-port data memory:
// byte-addressed loads/stores with sub-word extraction and read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WordSize  = 32,
    parameter int AddrWidth = 8
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [1:0]           ReqSize,
    input  logic                 ReqUnsigned,
    input  logic [AddrWidth+1:0] ReqAddr,
    input  logic [WordSize-1:0]  ReqWData,
    output logic                 RspValid,
    output logic                 RspError,
    output logic [WordSize-1:0]  RspRData,
    output logic                 MemStatus,
    output logic [AddrWidth-1:0] MemAddress,
    output logic [WordSize-1:0]  MemI,
    input  logic [WordSize-1:0]  MemQ
);

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    size_e                size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [1:0]           lane_q, lane_d;
    logic [WordSize-1:0]  wdata_q, wdata_d;
    logic                 mem_status_q, mem_status_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [WordSize-1:0]  mem_i_q, mem_i_d;
    logic [WordSize-1:0]  rdata_q, rdata_d;

    logic [WordSize-1:0]  load_val;
    logic [WordSize-1:0]  merge_word;

    mem_lane_align #(
        .WordSize(WordSize)
    ) u_align (
        .size_i       (size_q),
        .lane_i       (lane_q),
        .unsigned_i   (unsigned_q),
        .old_word_i   (MemQ),
        .store_data_i (wdata_q),
        .load_data_o  (load_val),
        .merged_word_o(merge_word)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_status_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_i_d      = mem_i_q;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d    = ReqWrite;
                    size_d     = size_e'(ReqSize);
                    unsigned_d = ReqUnsigned;
                    lane_d     = ReqAddr[1:0];
                    wdata_d    = ReqWData;
                    if (access_error(size_e'(ReqSize), ReqAddr[1:0])) begin
                        state_d = ERR;
                        rdata_d = '0;
                    end else if (!ReqWrite || size_e'(ReqSize) != SIZE_W) begin
                        state_d    = READ;
                        mem_addr_d = ReqAddr[AddrWidth+1:2];
                    end else begin
                        state_d      = WRITE;
                        mem_addr_d   = ReqAddr[AddrWidth+1:2];
                        mem_i_d      = ReqWData;
                        mem_status_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    state_d      = WRITE;
                    mem_i_d      = merge_word;
                    mem_status_d = 1'b1;
                end else begin
                    state_d = RESP;
                    rdata_d = load_val;
                end
            end
            WRITE: begin
                // Status drops on this edge while the address is still held.
                state_d = RESP;
                rdata_d = '0;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= SIZE_B;
            unsigned_q   <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            mem_status_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_i_q      <= '0;
            rdata_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_status_q <= mem_status_d;
            mem_addr_q   <= mem_addr_d;
            mem_i_q      <= mem_i_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ReqReady   = (state_q == IDLE);
    assign RspValid   = (state_q == RESP) || (state_q == ERR);
    assign RspError   = (state_q == ERR);
    assign RspRData   = rdata_q;
    assign MemStatus  = mem_status_q;
    assign MemAddress = mem_addr_q;
    assign MemI       = mem_i_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a level-sensitive memory model and
// hand-computed expected values per scenario.
module tb_mem_access_ctrl;

    logic        Clk;
    logic        RstN;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [9:0]  ReqAddr;
    logic [31:0] ReqWData;
    logic        RspValid;
    logic        RspError;
    logic [31:0] RspRData;
    logic        MemStatus;
    logic [7:0]  MemAddress;
    logic [31:0] MemI;
    logic [31:0] MemQ;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.WordSize(32), .AddrWidth(8)) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqSize    (ReqSize),
        .ReqUnsigned(ReqUnsigned),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .RspValid   (RspValid),
        .RspError   (RspError),
        .RspRData   (RspRData),
        .MemStatus  (MemStatus),
        .MemAddress (MemAddress),
        .MemI       (MemI),
        .MemQ       (MemQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: untouched words read as {A5, addr, 5A, addr}.
    logic [31:0] mem [256];
    bit          written [256];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return {8'hA5, a, 8'h5A, a};
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return written[a] ? mem[a] : init_word(a);
    endfunction

    assign MemQ = mem_word(MemAddress);

    always @(posedge Clk) begin
        if (MemStatus) begin
            mem[MemAddress]     <= MemI;
            written[MemAddress] <= 1'b1;
        end
    end

    int          wr_cycles  = 0;
    int          rsp_pulses = 0;
    logic [7:0]  last_wr_addr;
    logic [31:0] last_wr_data;

    always @(negedge Clk) begin
        if (MemStatus) begin
            wr_cycles    <= wr_cycles + 1;
            last_wr_addr <= MemAddress;
            last_wr_data <= MemI;
        end
        if (RspValid) rsp_pulses <= rsp_pulses + 1;
    end

    // Issues one request from a negedge and returns the accept-to-response latency.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [9:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        n   = 0;
        while (!ReqReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqUnsigned = u;
        ReqAddr  = a;    ReqWData = wd;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (RspValid) begin
                lat = i;
                rd  = RspRData;
                er  = RspError;
                break;
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_reset;
        if (ReqReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ReqReady); end
        checks++;
        if (RspValid !== 1'b0 || RspError !== 1'b0) begin
            failures++; $display("FAIL reset_rsp got=%b%b exp=00", RspValid, RspError);
        end
        checks++;
        if (RspRData !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", RspRData); end
        checks++;
        if (MemStatus !== 1'b0) begin failures++; $display("FAIL reset_status got=%b exp=0", MemStatus); end
        checks++;
        if (MemAddress !== 8'h0 || MemI !== 32'h0) begin
            failures++; $display("FAIL reset_mem got=%h/%h exp=0/0", MemAddress, MemI);
        end
        checks++;
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = wr_cycles;
        do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, lat, rd, er);
        if (lat !== 2) begin failures++; $display("FAIL wst_latency got=%0d exp=2", lat); end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL wst_rsp got=%b/%h exp=0/0", er, rd); end
        checks++;
        if (wr_cycles - w0 !== 1) begin failures++; $display("FAIL wst_wr_cycles got=%0d exp=1", wr_cycles - w0); end
        checks++;
        if (last_wr_addr !== 8'h04 || last_wr_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wst_mem got=%h/%h exp=04/deadbeef", last_wr_addr, last_wr_data);
        end
        checks++;
        w0 = wr_cycles;
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, er);
        if (lat !== 2) begin failures++; $display("FAIL wld_latency got=%0d exp=2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL wld_data got=%h/%b exp=deadbeef/0", rd, er); end
        checks++;
        if (wr_cycles != w0) begin failures++; $display("FAIL wld_no_write got=%0d exp=%0d", wr_cycles, w0); end
        checks++;
    endtask

    task automatic test_byte_store;
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = wr_cycles;
        do_req(1'b1, 2'b00, 1'b0, 10'h012, 32'h0000007A, lat, rd, er);
        if (lat !== 3) begin failures++; $display("FAIL bst_latency got=%0d exp=3", lat); end
        checks++;
        if (wr_cycles - w0 !== 1 || last_wr_data !== 32'hDE7ABEEF) begin
            failures++; $display("FAIL bst_write got=%0d/%h exp=1/de7abeef", wr_cycles - w0, last_wr_data);
        end
        checks++;
        if (mem_word(8'h04) !== 32'hDE7ABEEF) begin failures++; $display("FAIL bst_mem got=%h exp=de7abeef", mem_word(8'h04)); end
        checks++;
    endtask

    task automatic test_load_ext;
        logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0]  ad [5] = '{10'h013, 10'h013, 10'h012, 10'h012, 10'h011};
        logic [31:0] ex [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDE7A, 32'h0000DE7A, 32'hFFFFFFBE};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er);
            if (lat !== 2 || rd !== ex[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL load_ext_%0d got=%0d/%h/%b exp=2/%h/0", i, lat, rd, er, ex[i]);
            end
            checks++;
        end
    endtask

    task automatic test_half_store;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b01, 1'b0, 10'h012, 32'h1234CAFE, lat, rd, er);
        if (lat !== 3 || mem_word(8'h04) !== 32'hCAFEBEEF) begin
            failures++; $display("FAIL hst got=%0d/%h exp=3/cafebeef", lat, mem_word(8'h04));
        end
        checks++;
        do_req(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, lat, rd, er);
        if (rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL hld_low got=%h exp=ffffbeef", rd); end
        checks++;
    endtask

    task automatic test_errors;
        logic [1:0] sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [9:0] ad [3] = '{10'h011, 10'h016, 10'h010};
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = wr_cycles;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, sz[i], 1'b0, ad[i], 32'h55555555, lat, rd, er);
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
                failures++; $display("FAIL err_%0d got=%0d/%b/%h exp=1/1/0", i, lat, er, rd);
            end
            checks++;
        end
        if (wr_cycles != w0 || mem_word(8'h04) !== 32'hCAFEBEEF || mem_word(8'h05) !== init_word(8'h05)) begin
            failures++; $display("FAIL err_no_write got=%0d/%h exp=%0d/cafebeef", wr_cycles, mem_word(8'h04), w0);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        logic [9:0]  ha [3] = '{10'h020, 10'h024, 10'h029};
        logic [1:0]  hs [3] = '{2'b10, 2'b10, 2'b00};
        logic [31:0] he [3] = '{32'hA5085A08, 32'hA5095A09, 32'h0000005A};
        logic [31:0] got [3];
        int acc [3];
        int idx, nrsp;
        logic rdy;
        idx = 0; nrsp = 0;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqUnsigned = 1'b1; ReqWData = 32'h0;
        ReqAddr = ha[0]; ReqSize = hs[0];
        for (int c = 0; c < 20; c++) begin
            rdy = ReqReady;
            if (RspValid) begin
                if (nrsp < 3) got[nrsp] = RspRData;
                nrsp++;
            end
            @(posedge Clk);
            #1;
            if (rdy && ReqValid) begin
                acc[idx] = c;
                idx++;
                if (idx < 3) begin
                    ReqAddr = ha[idx]; ReqSize = hs[idx];
                end else begin
                    ReqValid = 1'b0;
                end
            end
            @(negedge Clk);
        end
        if (idx !== 3 || nrsp !== 3) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", idx, nrsp); end
        checks++;
        if (idx == 3 && (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)) begin
            failures++; $display("FAIL b2b_spacing got=%0d/%0d/%0d exp=step 3", acc[0], acc[1], acc[2]);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            if (i < nrsp && got[i] !== he[i]) begin
                failures++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, got[i], he[i]);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_write;
        int p0;
        p0 = rsp_pulses;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqUnsigned = 1'b0;
        ReqAddr = 10'h031; ReqWData = 32'h00000055;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        @(posedge Clk);
        #1;
        if (MemStatus !== 1'b1) begin failures++; $display("FAIL rmw_in_write got=%b exp=1", MemStatus); end
        checks++;
        RstN = 1'b0;
        #1;
        if (MemStatus !== 1'b0 || MemAddress !== 8'h0 || MemI !== 32'h0) begin
            failures++; $display("FAIL rst_mid_mem got=%b/%h/%h exp=0/0/0", MemStatus, MemAddress, MemI);
        end
        checks++;
        if (RspValid !== 1'b0 || RspError !== 1'b0 || RspRData !== 32'h0) begin
            failures++; $display("FAIL rst_mid_rsp got=%b/%b/%h exp=0/0/0", RspValid, RspError, RspRData);
        end
        checks++;
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        repeat (3) @(negedge Clk);
        if (ReqReady !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ReqReady); end
        checks++;
        if (rsp_pulses != p0) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d exp=%0d", rsp_pulses, p0); end
        checks++;
        if (mem_word(8'h0C) !== 32'hA50C5A0C) begin
            failures++; $display("FAIL rst_mid_mem_word got=%h exp=a50c5a0c", mem_word(8'h0C));
        end
        checks++;
    endtask

    initial begin
        RstN = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqUnsigned = 1'b0; ReqAddr = '0; ReqWData = '0;
        #2;
        test_reset;
        @(negedge Clk);
        RstN = 1'b1;
        @(negedge Clk);
        test_word;
        test_byte_store;
        test_load_ext;
        test_half_store;
        test_errors;
        test_back_to_back;
        test_reset_mid_write;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
